// File: rtl/sys_mem_sram_pkg.sv
// Shared constants for the sys_mem to asynchronous SRAM responder.
// Holds the FSM state encoding, access timing floor, reject data and half-select encoding.
package sys_mem_sram_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_WR_LO = 3'd1;
    localparam state_t ST_WR_HI = 3'd2;
    localparam state_t ST_RD_LO = 3'd3;
    localparam state_t ST_RD_HI = 3'd4;
    localparam state_t ST_REJ   = 3'd5;

    localparam int unsigned ACC_CYCLES_MIN = 2;

    localparam logic [31:0] DEFAULT_RD_VAL = 32'hDEAD_BABE;

    localparam logic HALF_LO = 1'b0;
    localparam logic HALF_HI = 1'b1;

endpackage

// File: rtl/sys_mem_sram_ctrl.sv
// sys_mem responder: each 32-bit word request becomes two 16-bit SRAM accesses, lower half first.
// SRAM strobes, address and write data are registered from the next-state decode so they line up with state_q.
module sys_mem_sram_ctrl #(
    parameter int unsigned SYS_MEM_DATA_W    = 32,
    parameter int unsigned SYS_MEM_ADDR_W    = 27,
    parameter int unsigned SRAM_ADDR_W       = 18,
    parameter int unsigned SRAM_DATA_W       = 16,
    parameter int unsigned SYS_MEM_STOP_ADDR = 131071,
    parameter int unsigned ACC_CYCLES        = 2,
    parameter logic [SYS_MEM_DATA_W-1:0] DEFAULT_RD_VAL = sys_mem_sram_pkg::DEFAULT_RD_VAL
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      sys_mem_wren,
    input  logic                      sys_mem_rden,
    input  logic [SYS_MEM_ADDR_W-1:0] sys_mem_addr,
    input  logic [SYS_MEM_DATA_W-1:0] sys_mem_wdata,
    output logic                      sys_mem_wait,
    output logic                      sys_mem_rd_valid,
    output logic [SYS_MEM_DATA_W-1:0] sys_mem_rdata,
    output logic [SRAM_ADDR_W-1:0]    sram_addr,
    inout  wire  [SRAM_DATA_W-1:0]    sram_dq,
    output logic                      sram_ce_n,
    output logic                      sram_oe_n,
    output logic                      sram_we_n,
    output logic                      sram_ub_n,
    output logic                      sram_lb_n
);
    import sys_mem_sram_pkg::*;

    localparam int unsigned ACC_EFF  = (ACC_CYCLES < ACC_CYCLES_MIN) ? ACC_CYCLES_MIN : ACC_CYCLES;
    localparam int unsigned CNT_W    = $clog2(ACC_EFF);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACC_EFF - 1);
    localparam int unsigned WA_W     = SRAM_ADDR_W - 1;
    localparam int unsigned DW       = SRAM_DATA_W;

    state_t                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [WA_W-1:0]           addr_q, addr_d;
    logic [SYS_MEM_DATA_W-1:0] wdata_q, wdata_d;
    logic                      dflt_rd_q, dflt_rd_d;
    logic [SYS_MEM_DATA_W-1:0] rdata_q, rdata_d;
    logic                      rd_valid_q, rd_valid_d;
    logic [SRAM_ADDR_W-1:0]    sram_addr_q, sram_addr_d;
    logic                      ce_n_q, ce_n_d;
    logic                      oe_n_q, oe_n_d;
    logic                      we_n_q, we_n_d;
    logic                      bl_n_q, bl_n_d;
    logic                      dq_oe_q, dq_oe_d;
    logic [DW-1:0]             dq_out_q, dq_out_d;

    logic last_s, done_s, req_s, in_range_s, acc_wr_s, acc_rd_s, half_s;

    assign last_s     = (cnt_q == CNT_LAST);
    assign done_s     = (state_q == ST_REJ) ||
                        (((state_q == ST_WR_HI) || (state_q == ST_RD_HI)) && last_s);
    assign req_s      = sys_mem_wren | sys_mem_rden;
    assign in_range_s = (sys_mem_addr <= SYS_MEM_ADDR_W'(SYS_MEM_STOP_ADDR));

    // Access sequencing, request latching and read-data capture.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        dflt_rd_d  = dflt_rd_q;
        rdata_d    = rdata_q;
        rd_valid_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = {CNT_W{1'b0}};
                if (req_s && in_range_s) begin
                    addr_d    = sys_mem_addr[WA_W-1:0];
                    wdata_d   = sys_mem_wdata;
                    // A simultaneous read is retired by the write with the default word.
                    dflt_rd_d = sys_mem_wren & sys_mem_rden;
                    state_d   = sys_mem_wren ? ST_WR_LO : ST_RD_LO;
                end else if (req_s) begin
                    dflt_rd_d = sys_mem_rden;
                    state_d   = ST_REJ;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_WR_LO, ST_RD_LO: begin
                if (last_s) begin
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = (state_q == ST_WR_LO) ? ST_WR_HI : ST_RD_HI;
                    if (state_q == ST_RD_LO) begin
                        rdata_d[DW-1:0] = sram_dq;
                    end else begin
                        rdata_d = rdata_q;
                    end
                end else begin
                    cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            ST_WR_HI: begin
                if (last_s) begin
                    state_d    = ST_IDLE;
                    rd_valid_d = dflt_rd_q;
                    rdata_d    = dflt_rd_q ? DEFAULT_RD_VAL : rdata_q;
                end else begin
                    cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            ST_RD_HI: begin
                if (last_s) begin
                    state_d           = ST_IDLE;
                    rd_valid_d        = 1'b1;
                    rdata_d[2*DW-1:DW] = sram_dq;
                end else begin
                    cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            ST_REJ: begin
                state_d    = ST_IDLE;
                rd_valid_d = dflt_rd_q;
                rdata_d    = dflt_rd_q ? DEFAULT_RD_VAL : rdata_q;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = {CNT_W{1'b0}};
            end
        endcase
    end

    // SRAM pin values for the cycle entered next; we_n rises in the last cycle for hold time.
    always_comb begin
        acc_wr_s = (state_d == ST_WR_LO) || (state_d == ST_WR_HI);
        acc_rd_s = (state_d == ST_RD_LO) || (state_d == ST_RD_HI);
        half_s   = ((state_d == ST_WR_HI) || (state_d == ST_RD_HI)) ? HALF_HI : HALF_LO;
        if (acc_wr_s || acc_rd_s) begin
            sram_addr_d = {addr_d, half_s};
        end else begin
            sram_addr_d = sram_addr_q;
        end
        ce_n_d   = ~(acc_wr_s | acc_rd_s);
        oe_n_d   = ~acc_rd_s;
        we_n_d   = ~(acc_wr_s && (cnt_d != CNT_LAST));
        bl_n_d   = ~(acc_wr_s | acc_rd_s);
        dq_oe_d  = acc_wr_s;
        dq_out_d = (half_s == HALF_HI) ? wdata_d[2*DW-1:DW] : wdata_d[DW-1:0];
    end

    // State and output registers; reset releases the bus and raises every strobe at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= {CNT_W{1'b0}};
            addr_q      <= {WA_W{1'b0}};
            wdata_q     <= {SYS_MEM_DATA_W{1'b0}};
            dflt_rd_q   <= 1'b0;
            rdata_q     <= {SYS_MEM_DATA_W{1'b0}};
            rd_valid_q  <= 1'b0;
            sram_addr_q <= {SRAM_ADDR_W{1'b0}};
            ce_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
            bl_n_q      <= 1'b1;
            dq_oe_q     <= 1'b0;
            dq_out_q    <= {DW{1'b0}};
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            dflt_rd_q   <= dflt_rd_d;
            rdata_q     <= rdata_d;
            rd_valid_q  <= rd_valid_d;
            sram_addr_q <= sram_addr_d;
            ce_n_q      <= ce_n_d;
            oe_n_q      <= oe_n_d;
            we_n_q      <= we_n_d;
            bl_n_q      <= bl_n_d;
            dq_oe_q     <= dq_oe_d;
            dq_out_q    <= dq_out_d;
        end
    end

    assign sys_mem_wait     = ~done_s;
    assign sys_mem_rd_valid = rd_valid_q;
    assign sys_mem_rdata    = rdata_q;
    assign sram_addr        = sram_addr_q;
    assign sram_ce_n        = ce_n_q;
    assign sram_oe_n        = oe_n_q;
    assign sram_we_n        = we_n_q;
    assign sram_ub_n        = bl_n_q;
    assign sram_lb_n        = bl_n_q;
    assign sram_dq          = dq_oe_q ? dq_out_q : {DW{1'bz}};

endmodule

// File: tb/tb_sys_mem_sram_ctrl.sv
// Scoreboard bench: instance 0 runs ACC_CYCLES=2, instance 1 runs ACC_CYCLES=3, each with an SRAM model.
// Drivers push expected completion cycles and read words; a negedge monitor pops and compares them.
module tb_sys_mem_sram_ctrl;
    localparam int N = 2;

    logic        clk = 1'b0;
    logic        rst_n   [N];
    logic        wren    [N];
    logic        rden    [N];
    logic [26:0] addr    [N];
    logic [31:0] wdata   [N];
    logic        mwait   [N];
    logic        rdv     [N];
    logic [31:0] rdata   [N];
    logic [17:0] saddr   [N];
    logic        ce_n    [N];
    logic        oe_n    [N];
    logic        we_n    [N];
    logic        ub_n    [N];
    logic        lb_n    [N];
    logic [15:0] dq_obs  [N];
    logic        probe_en[N];
    logic [15:0] mem     [N][262144];

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int we_cnt[N];
    int ce_cnt[N];
    bit contention = 1'b0;

    typedef struct { int dut; int cyc; } done_t;
    typedef struct { int dut; int cyc; logic [31:0] data; } rd_t;
    done_t done_q[$];
    rd_t   rd_q[$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        wire [15:0] dq_w;
        sys_mem_sram_ctrl #(.ACC_CYCLES((g == 0) ? 2 : 3)) u_dut (
            .clk(clk), .rst_n(rst_n[g]),
            .sys_mem_wren(wren[g]), .sys_mem_rden(rden[g]),
            .sys_mem_addr(addr[g]), .sys_mem_wdata(wdata[g]),
            .sys_mem_wait(mwait[g]), .sys_mem_rd_valid(rdv[g]), .sys_mem_rdata(rdata[g]),
            .sram_addr(saddr[g]), .sram_dq(dq_w),
            .sram_ce_n(ce_n[g]), .sram_oe_n(oe_n[g]), .sram_we_n(we_n[g]),
            .sram_ub_n(ub_n[g]), .sram_lb_n(lb_n[g])
        );
        // SRAM read drive, or a known probe pattern used to show the DUT has released the bus.
        assign dq_w = (!ce_n[g] && !oe_n[g] && we_n[g]) ? mem[g][saddr[g]]
                    : (probe_en[g] ? 16'h5A5A : 16'hzzzz);
        assign dq_obs[g] = dq_w;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h expected=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int k = 0; k < N; k++) begin
            if (!ce_n[k] && !we_n[k]) mem[k][saddr[k]] <= dq_obs[k];
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < N; k++) begin
            if (!ce_n[k] && !we_n[k]) we_cnt[k]++;
            if (!ce_n[k]) ce_cnt[k]++;
            if (!oe_n[k] && !we_n[k]) contention = 1'b1;
        end
    end

    // Monitor: compares every acceptance and every read strobe against the scoreboard.
    always @(negedge clk) begin
        rd_t   re;
        done_t de;
        for (int k = 0; k < N; k++) begin
            if (rdv[k]) begin
                if (rd_q.size() == 0) begin
                    chk("rd_unexpected", 32'd1, 32'd0);
                end else begin
                    re = rd_q.pop_front();
                    chk("rd_dut", k, re.dut);
                    chk("rd_cyc", cyc, re.cyc);
                    chk("rd_data", rdata[k], re.data);
                end
            end
            if ((wren[k] || rden[k]) && !mwait[k]) begin
                if (done_q.size() == 0) begin
                    chk("done_unexpected", 32'd1, 32'd0);
                end else begin
                    de = done_q.pop_front();
                    chk("done_dut", k, de.dut);
                    chk("done_cyc", cyc, de.cyc);
                end
            end
        end
    end

    // Issue one request at cycle 0 (called #1 after a rising edge) and drop it after acceptance.
    task automatic req(input int k, input bit wr, input bit rd, input logic [26:0] a,
                       input logic [31:0] d, input int off, input bit exp_rd,
                       input logic [31:0] exp_d);
        done_t de;
        rd_t   re;
        int    n;
        de.dut = k;
        de.cyc = cyc + off;
        done_q.push_back(de);
        if (exp_rd) begin
            re.dut  = k;
            re.cyc  = cyc + off + 1;
            re.data = exp_d;
            rd_q.push_back(re);
        end
        wren[k] = wr; rden[k] = rd; addr[k] = a; wdata[k] = d;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (mwait[k] && n < 50);
        if (mwait[k]) chk("req_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1;
        wren[k] = 1'b0; rden[k] = 1'b0;
    endtask

    task automatic chk_released(input int k, input string name);
        chk({name, "_strobes"}, {27'd0, ce_n[k], oe_n[k], we_n[k], ub_n[k], lb_n[k]}, 32'h1F);
        probe_en[k] = 1'b1;
        #1;
        chk({name, "_dq"}, {16'd0, dq_obs[k]}, 32'h5A5A);
        probe_en[k] = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          w0, c0;
        logic [15:0] m0, m1;
        logic [26:0] ba[16];
        logic [31:0] bd[16];

        for (int k = 0; k < N; k++) begin
            rst_n[k] = 1'b0; wren[k] = 1'b0; rden[k] = 1'b0;
            addr[k] = 27'd0; wdata[k] = 32'd0; probe_en[k] = 1'b0;
            we_cnt[k] = 0; ce_cnt[k] = 0;
        end
        repeat (3) @(posedge clk);
        #2;
        for (int k = 0; k < N; k++) begin
            chk("rst_wait", {31'd0, mwait[k]}, 32'd1);
            chk("rst_rd_valid", {31'd0, rdv[k]}, 32'd0);
            chk("rst_rdata", rdata[k], 32'd0);
            chk("rst_addr", {14'd0, saddr[k]}, 32'd0);
            chk_released(k, "rst");
        end
        @(posedge clk); #1;
        rst_n[0] = 1'b1; rst_n[1] = 1'b1;
        @(posedge clk); #1;

        // Basic write of 0xCAFEF00D to word 0x10.
        w0 = we_cnt[0];
        req(0, 1'b1, 1'b0, 27'h10, 32'hCAFE_F00D, 4, 1'b0, 32'd0);
        chk("wr_lo", {16'd0, mem[0][32'h20]}, 32'h0000_F00D);
        chk("wr_hi", {16'd0, mem[0][32'h21]}, 32'h0000_CAFE);
        chk("wr_we_cycles", we_cnt[0] - w0, 32'd2);

        req(0, 1'b0, 1'b1, 27'h10, 32'd0, 4, 1'b1, 32'hCAFE_F00D);

        // Out-of-range read and write: no SRAM activity.
        c0 = ce_cnt[0]; m0 = mem[0][0]; m1 = mem[0][1];
        req(0, 1'b0, 1'b1, 27'h20000, 32'd0, 1, 1'b1, 32'hDEAD_BABE);
        req(0, 1'b1, 1'b0, 27'h20000, 32'h1111_2222, 1, 1'b0, 32'd0);
        chk("rej_ce_activity", ce_cnt[0] - c0, 32'd0);
        chk("rej_mem0", {16'd0, mem[0][0]}, {16'd0, m0});
        chk("rej_mem1", {16'd0, mem[0][1]}, {16'd0, m1});

        // wren and rden together: write happens, read retires with the default word.
        req(0, 1'b1, 1'b1, 27'h5, 32'h1234_5678, 4, 1'b1, 32'hDEAD_BABE);
        chk("both_lo", {16'd0, mem[0][32'hA]}, 32'h0000_5678);
        chk("both_hi", {16'd0, mem[0][32'hB]}, 32'h0000_1234);

        // Reset during WR_HI, then a normal read of another word.
        wren[0] = 1'b1; addr[0] = 27'h30; wdata[0] = 32'hAAAA_5555;
        repeat (3) @(posedge clk);
        #2;
        rst_n[0] = 1'b0;
        #1;
        chk_released(0, "midrst");
        wren[0] = 1'b0;
        @(posedge clk); #1;
        rst_n[0] = 1'b1;
        @(posedge clk); #1;
        req(0, 1'b0, 1'b1, 27'h10, 32'd0, 4, 1'b1, 32'hCAFE_F00D);

        // Back-to-back on the ACC_CYCLES=3 instance, including the highest valid word.
        for (int i = 0; i < 16; i++) begin
            ba[i] = 27'(i * 8191 + 2);
            bd[i] = $urandom;
        end
        ba[15] = 27'd131071;
        for (int i = 0; i < 16; i++) req(1, 1'b1, 1'b0, ba[i], bd[i], 6, 1'b0, 32'd0);
        for (int i = 0; i < 16; i++) req(1, 1'b0, 1'b1, ba[i], 32'd0, 6, 1'b1, bd[i]);

        repeat (10) @(posedge clk);
        chk("rd_q_drained", rd_q.size(), 32'd0);
        chk("done_q_drained", done_q.size(), 32'd0);
        chk("oe_we_overlap", {31'd0, contention}, 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
